demux1to4_stream: RTL and testbench
===================================

// Module: demux1to4_stream
// PURPOSE
//   Registered 1-to-4 demultiplexer; the write-side counterpart of mux4to1.
//   Routes one input word (valid/ready) to one of four output channels, selected by {S1,S2}.
//   Each output has a one-entry holding register, so channels drain independently.
//   Sits ahead of mux4to1 in the mux/demux loopback path.
// PARAMETERS
//   W      1    data width of I and Y0..Y3
//   CNT_W  8    width of the per-channel transfer counters (wrapping)
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   I          in   W      input data word
//   S1         in   1      select MSB; channel = {S1,S2}
//   S2         in   1      select LSB
//   in_valid   in   1      input word + select valid this cycle
//   in_ready   out  1      block accepts the input this cycle
//   Y0..Y3     out  W      channel data, from holding register
//   y_valid    out  4      bit k: Yk holds an undelivered word
//   y_ready    in   4      bit k: consumer of channel k takes Yk this cycle
//   cnt0..cnt3 out  CNT_W  words delivered on channel k (y_valid&y_ready), wrapping
// BEHAVIOUR
//   Reset (rst_n=0, async): y_valid=4'b0, Y0..Y3=0, cnt0..cnt3=0; in_ready=0 while rst_n=0.
//   Select: k = {S1,S2}: 00->Y0, 01->Y1, 10->Y2, 11->Y3. Sampled only with in_valid.
//   in_ready (combinational) = rst_n & (~y_valid[k] | y_ready[k]); depends on k only.
//   Accept = in_valid & in_ready; next edge: Yk<=I, y_valid[k]<=1. Latency 1 clock.
//   Deliver on channel j = y_valid[j] & y_ready[j]; next edge: y_valid[j]<=0 unless
//     accept targets j the same cycle, then Yj<=I, y_valid[j] stays 1.
//   Holding register full and y_ready[k]=0: in_ready=0; no data loss, no overwrite.
//   Other channels deliver concurrently regardless of which channel is selected.
//   in_valid=1 with in_ready=0: I, S1, S2 may change; the block samples nothing.
//   Y data is stable while y_valid[j]=1 and y_ready[j]=0.
//   When y_valid[j]=0, Yj holds its last value; it is not cleared.
//   Counters: cntj increments by 1 on each deliver; CNT_W'1 +1 wraps to 0.
//   Reset mid-transfer: in-flight words are discarded; the counters clear.
//   Per-channel FSM {EMPTY, FULL}:
//     EMPTY->FULL on accept.
//     FULL->EMPTY on deliver without accept.
//     FULL->FULL on deliver+accept, or on neither.
// STRUCTURE
//   Package demux_pkg: NUM_CH=4, SEL_W=2, typedef chan_state_e {EMPTY, FULL},
//   function sel2ch({S1,S2}).
//   Sub-module demux_slot (instantiated 4x):
//     ports: clk, rst_n, wr_en, wr_data, rd_ready, rd_data, rd_valid, cnt.
//     holds the one-entry register, the FSM and the counter.
//   Top level: select decode, in_ready mux, wr_en one-hot fan-out.
// TESTING
//   1 Reset: rst_n=0 with in_valid=1 -> y_valid=0000, cnt*=0, in_ready=0;
//     after release in_ready=1.
//   2 Route sweep, y_ready=1111. Drive I=1,0,1,0 with {S1,S2}=00,01,10,11 on consecutive cycles.
//     -> Y0=1, Y1=0, Y2=1, Y3=0, each valid exactly 1 cycle after accept; cnt0..cnt3=1.
//   3 Backpressure: y_ready[2]=0; send I=1 to ch2, then I=0 to ch2.
//     -> second word stalls (in_ready=0), Y2 stays 1.
//     Raise y_ready[2] -> 0 accepted same cycle, Y2=0 next edge.
//   4 Independence: ch1 full and stalled; send {S1,S2}=11, I=1 -> accepted, Y3=1.
//     y_valid[1] is unchanged.
//   5 Wrap: CNT_W=8; 256 deliveries on ch0 -> cnt0 returns to 0; no other counter moves.
//   6 Mid-op reset: ch0..ch3 all full; pulse rst_n low between edges.
//     -> y_valid=0000 immediately (async); cnt*=0; first post-reset accept behaves as case 2.

Source files
------------

// File: rtl/demux_pkg.sv
// demux_pkg: shared types and helpers for the 1-to-4 stream demux.
// Channel count, select width, slot state and select decode.
package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_e;

  // {S1,S2} maps straight onto the channel index, S1 being the MSB.
  function automatic logic [SEL_W-1:0] sel2ch(
    input logic [SEL_W-1:0] sel
  );
    return sel;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry holding register for a single output channel,
// with its EMPTY/FULL state and a wrapping delivered-word counter.
module demux_slot
  import demux_pkg::*;
#(
  parameter int W     = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [W-1:0]     wr_data,
  input  logic             rd_ready,
  output logic [W-1:0]     rd_data,
  output logic             rd_valid,
  output logic [CNT_W-1:0] cnt
);

  chan_state_e state_q;
  chan_state_e state_d;
  logic        deliver;

  assign rd_valid = (state_q == FULL);
  assign deliver  = rd_valid & rd_ready;

  // Slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // A write always leaves the slot full; a lone deliver empties it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (wr_en) state_d = FULL;
      FULL:  if (deliver && !wr_en) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Capture the word; otherwise keep the last value, even once drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (wr_en) rd_data <= wr_data;
  end

  // Count words handed to the consumer, wrapping at full scale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt <= '0;
    else if (deliver) cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/demux1to4_stream.sv
// demux1to4_stream: registered 1-to-4 valid/ready demultiplexer.
// Decodes {S1,S2}, gates in_ready on the chosen slot, fans out the write.
module demux1to4_stream
  import demux_pkg::*;
#(
  parameter int W     = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     I,
  input  logic             S1,
  input  logic             S2,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W-1:0]     Y0,
  output logic [W-1:0]     Y1,
  output logic [W-1:0]     Y2,
  output logic [W-1:0]     Y3,
  output logic [3:0]       y_valid,
  input  logic [3:0]       y_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
);

  logic [SEL_W-1:0]  ch;
  logic              accept;
  logic [NUM_CH-1:0] wr_en;
  logic [W-1:0]      y_data [NUM_CH];
  logic [CNT_W-1:0]  cnt    [NUM_CH];

  assign ch = sel2ch({S1, S2});

  // Ready follows only the selected slot: free now or draining this cycle.
  always_comb begin
    in_ready = rst_n & (~y_valid[ch] | y_ready[ch]);
    accept   = in_valid & in_ready;
    wr_en    = '0;
    if (accept) wr_en = NUM_CH'(1) << ch;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    demux_slot #(
      .W     (W),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en[g]),
      .wr_data  (I),
      .rd_ready (y_ready[g]),
      .rd_data  (y_data[g]),
      .rd_valid (y_valid[g]),
      .cnt      (cnt[g])
    );
  end

  assign Y0   = y_data[0];
  assign Y1   = y_data[1];
  assign Y2   = y_data[2];
  assign Y3   = y_data[3];
  assign cnt0 = cnt[0];
  assign cnt1 = cnt[1];
  assign cnt2 = cnt[2];
  assign cnt3 = cnt[3];

endmodule

// File: tb/tb_demux1to4_stream.sv
// tb_demux1to4_stream: directed checks of routing, backpressure,
// channel independence, counter wrap and asynchronous reset.
module tb_demux1to4_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:0] din;
  logic       S1, S2;
  logic       in_valid;
  logic       in_ready;
  logic [0:0] Y0, Y1, Y2, Y3;
  logic [3:0] y_valid;
  logic [3:0] y_ready;
  logic [7:0] cnt0, cnt1, cnt2, cnt3;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  demux1to4_stream #(.W(1), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .I        (din),
    .S1       (S1),
    .S2       (S2),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Y0       (Y0),
    .Y1       (Y1),
    .Y2       (Y2),
    .Y3       (Y3),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .cnt0     (cnt0),
    .cnt1     (cnt1),
    .cnt2     (cnt2),
    .cnt3     (cnt3)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] sel,
                       input logic d,
                       input logic v);
    {S1, S2} = sel;
    din      = d;
    in_valid = v;
    #1;
  endtask

  task automatic chk_cnt(input string tag,
                         input logic [7:0] c0, c1, c2, c3);
    chk({tag, "_cnt0"}, 32'(cnt0), 32'(c0));
    chk({tag, "_cnt1"}, 32'(cnt1), 32'(c1));
    chk({tag, "_cnt2"}, 32'(cnt2), 32'(c2));
    chk({tag, "_cnt3"}, 32'(cnt3), 32'(c3));
  endtask

  logic [3:0] rt_d;

  initial begin
    rst_n    = 1'b0;
    y_ready  = 4'b0000;
    drive(2'b00, 1'b1, 1'b1);

    // 1 reset
    tick();
    tick();
    chk("rst_yvalid", 32'(y_valid), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h0);
    chk_cnt("rst", 8'd0, 8'd0, 8'd0, 8'd0);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b1;
    #1;
    chk("rel_ready", 32'(in_ready), 32'h1);
    tick();

    // 2 route sweep
    y_ready = 4'b1111;
    rt_d = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      drive(2'(k), rt_d[k], 1'b1);
      chk($sformatf("rt%0d_ready", k), 32'(in_ready), 32'h1);
      tick();
      chk($sformatf("rt%0d_yv", k), 32'(y_valid), 32'h1 << k);
      case (k)
        0: chk("rt_y0", 32'(Y0), 32'h1);
        1: chk("rt_y1", 32'(Y1), 32'h0);
        2: chk("rt_y2", 32'(Y2), 32'h1);
        default: chk("rt_y3", 32'(Y3), 32'h0);
      endcase
    end
    drive(2'b00, 1'b0, 1'b0);
    tick();
    chk("rt_drained", 32'(y_valid), 32'h0);
    chk_cnt("rt", 8'd1, 8'd1, 8'd1, 8'd1);

    // 3 backpressure on ch2
    y_ready = 4'b1011;
    drive(2'b10, 1'b1, 1'b1);
    tick();
    chk("bp_y2a", 32'(Y2), 32'h1);
    drive(2'b10, 1'b0, 1'b1);
    chk("bp_stall", 32'(in_ready), 32'h0);
    tick();
    chk("bp_y2hold", 32'(Y2), 32'h1);
    chk("bp_yv", 32'(y_valid), 32'h4);
    chk("bp_cnt2", 32'(cnt2), 32'h1);
    y_ready = 4'b1111;
    #1;
    chk("bp_ready", 32'(in_ready), 32'h1);
    tick();
    chk("bp_y2b", 32'(Y2), 32'h0);
    chk("bp_yv2", 32'(y_valid), 32'h4);
    chk("bp_cnt2b", 32'(cnt2), 32'h2);
    drive(2'b00, 1'b0, 1'b0);
    tick();
    chk("bp_drained", 32'(y_valid), 32'h0);
    chk("bp_cnt2c", 32'(cnt2), 32'h3);

    // 4 independence: ch1 stalled, ch3 still accepts
    y_ready = 4'b0000;
    drive(2'b01, 1'b1, 1'b1);
    tick();
    drive(2'b01, 1'b0, 1'b1);
    chk("ind_ch1_stall", 32'(in_ready), 32'h0);
    drive(2'b11, 1'b1, 1'b1);
    chk("ind_ch3_ready", 32'(in_ready), 32'h1);
    tick();
    chk("ind_yv", 32'(y_valid), 32'hA);
    chk("ind_y3", 32'(Y3), 32'h1);
    chk("ind_y1", 32'(Y1), 32'h1);
    drive(2'b00, 1'b0, 1'b0);
    y_ready = 4'b1111;
    tick();
    chk("ind_drained", 32'(y_valid), 32'h0);
    chk_cnt("ind", 8'd1, 8'd2, 8'd3, 8'd2);

    // 5 counter wrap on ch0: 255 more deliveries lands on 0
    for (int i = 0; i < 255; i++) begin
      drive(2'b00, 1'(i), 1'b1);
      tick();
    end
    drive(2'b00, 1'b0, 1'b0);
    tick();
    chk_cnt("wrap", 8'd0, 8'd2, 8'd3, 8'd2);
    drive(2'b00, 1'b1, 1'b1);
    tick();
    drive(2'b00, 1'b0, 1'b0);
    tick();
    chk("wrap_cnt0b", 32'(cnt0), 32'h1);

    // 6 all full, then async reset between edges
    y_ready = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      drive(2'(k), 1'b1, 1'b1);
      tick();
    end
    drive(2'b00, 1'b0, 1'b0);
    chk("mr_full", 32'(y_valid), 32'hF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_yvalid", 32'(y_valid), 32'h0);
    chk("mr_ready", 32'(in_ready), 32'h0);
    chk("mr_y0", 32'(Y0), 32'h0);
    chk_cnt("mr", 8'd0, 8'd0, 8'd0, 8'd0);
    #1;
    rst_n = 1'b1;
    tick();
    y_ready = 4'b1111;
    drive(2'b10, 1'b1, 1'b1);
    chk("post_ready", 32'(in_ready), 32'h1);
    tick();
    chk("post_yv", 32'(y_valid), 32'h4);
    chk("post_y2", 32'(Y2), 32'h1);
    drive(2'b00, 1'b0, 1'b0);
    tick();
    chk("post_drained", 32'(y_valid), 32'h0);
    chk_cnt("post", 8'd0, 8'd0, 8'd1, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
